qmem_arb2: RTL
==============

Name: qmem_arb2

Overview:
- Two-master to one-slave arbiter on the qmem bus: adr, cs, we, sel, dat_w, dat_r, ack, err.
- Shares a single-port on-chip RAM between the data CPU (master 0) and a second requester (master 1: instruction fetch or DMA).
- The grant is a registered FSM. The owner's request is muxed to the slave, and the slave's ack and err are routed back to the owner only.
- Policy is round-robin by default; fixed priority when the optional macro is defined.

Parameters:
- QAW, 32, qmem address width
- QDW, 32, data width
- QSW, QDW/8, byte-select width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- m0_adr/m1_adr  in  QAW  master address
- m0_cs/m1_cs  in  1  master request/chip select
- m0_we/m1_we  in  1  write enable
- m0_sel/m1_sel  in  QSW  byte selects
- m0_dat_w/m1_dat_w  in  QDW  write data
- m0_dat_r/m1_dat_r  out  QDW  read data
- m0_ack/m1_ack  out  1  transfer acknowledge
- m0_err/m1_err  out  1  transfer error
- s_adr  out  QAW  slave address
- s_cs  out  1  slave chip select
- s_we  out  1  slave write enable
- s_sel  out  QSW  slave byte selects
- s_dat_w  out  QDW  slave write data
- s_dat_r  in  QDW  slave read data
- s_ack  in  1  slave acknowledge
- s_err  in  1  slave error

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- State: gnt register, one of GNT_NONE / GNT_M0 / GNT_M1; last register, 1 bit, records the master most recently granted.
- Reset values: gnt=GNT_NONE, last=1 (so master 0 wins the first tie). All outputs reset to 0: s_cs, s_we, s_adr, s_sel, s_dat_w, m*_ack, m*_err.
- Slave side, combinational from gnt:
  - gnt=GNT_Mx: s_* = mx_*, with s_cs = mx_cs.
  - gnt=GNT_NONE: all s_* = 0.
- Master side:
  - mx_ack = s_ack & (gnt==GNT_Mx).
  - mx_err = s_err & (gnt==GNT_Mx).
  - m0_dat_r = m1_dat_r = s_dat_r (broadcast). Each master samples dat_r per its own slave-latency knowledge; synchronous RAM data arrives one cycle after ack.
- No combinational path from any m*_cs to s_cs other than through the owner mux.
- Next-state rules, evaluated at posedge clk:
  - GNT_NONE, no requests: stay.
  - GNT_NONE, one request: grant that master.
  - GNT_NONE, both requesting: grant !last.
  - GNT_Mx, owner cs=1 and s_ack=0: hold (transfer stalled; the other master waits).
  - GNT_Mx, owner cs=1 and s_ack=1 (transfer done): if the other master requests, switch to it; else keep Mx.
  - GNT_Mx, owner cs=0 (idle or aborted): if the other master requests, grant it; else GNT_NONE.
  - last updates on every transition into GNT_M0 / GNT_M1.
- Latency:
  - From GNT_NONE: request in cycle N reaches s_cs in cycle N+1 (one arbitration cycle).
  - Back-to-back accesses by the owner, or alternating accesses at ack: one per cycle, no bubble.
- Contention:
  - Simultaneous requests at ack: alternate strictly (round-robin).
  - Starvation bound: one transfer.
- Reset mid-transfer: gnt returns to GNT_NONE immediately (async) and s_cs drops. Masters must reissue.
- Write data and sel are never altered; widths pass through unchanged.

Optional Feature:
- Macro: QMEM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins.
  - On tie in GNT_NONE, grant M0.
  - At M1 ack while m0_cs=1, switch to M0.
  - At M0 ack, keep M0 if m0_cs=1, even if m1_cs=1.
  - last is unused.
- Undefined: round-robin as above.

Decomposition:
- Package qmem_arb_pkg:
  - GNT_NONE=2'd0, GNT_M0=2'd1, GNT_M1=2'd2, 2-bit grant width.
- Single module, no sub-module required. The next-grant decision is a combinational function inside the block.

Test Plan:
- Reset, then m0_cs=1 read adr=0x10: s_cs=1 and s_adr=0x10 on the 2nd cycle; m0_ack=1 with s_ack; m1_ack=0 throughout.
- Both masters request from idle after reset (RR): M0 granted first. At its ack, M1 is granted the next cycle. Pattern M0,M1,M0,M1 over 4 acks.
- M1 writes dat_w=0xDEADBEEF sel=4'b0011 while slave holds s_ack=0 for 3 cycles: gnt stays M1; m0 request is not forwarded; s_dat_w and s_sel match M1 exactly.
- Owner drops cs before ack while the other requests: grant moves next edge, no ack to the dropped master.
- rst pulsed mid-transfer: s_cs=0 within the same cycle, gnt=GNT_NONE. After release, the tie goes to M0.
- QMEM_ARB_FIXED_PRIO_EN defined, both masters continuously requesting with s_ack=1: M0 granted every cycle, m1_ack never asserts. Drop m0_cs: M1 is granted the next edge.

Source files
------------

// File: rtl/qmem_arb_pkg.sv
// Shared definitions for the two-master qmem arbiter: grant encoding and width.
package qmem_arb_pkg;

  localparam int GNT_W = 2;

  typedef enum logic [GNT_W-1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_t;

endpackage

// File: rtl/qmem_arb2.sv
// Two-master to one-slave qmem arbiter. A registered grant selects which
// master's request is muxed onto the slave; ack/err return to the owner only
// and read data is broadcast. Round-robin by default; define
// QMEM_ARB_FIXED_PRIO_EN for fixed priority with master 0 always winning.
module qmem_arb2
  import qmem_arb_pkg::*;
#(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [QAW-1:0] m0_adr,
  input  logic           m0_cs,
  input  logic           m0_we,
  input  logic [QSW-1:0] m0_sel,
  input  logic [QDW-1:0] m0_dat_w,
  output logic [QDW-1:0] m0_dat_r,
  output logic           m0_ack,
  output logic           m0_err,
  input  logic [QAW-1:0] m1_adr,
  input  logic           m1_cs,
  input  logic           m1_we,
  input  logic [QSW-1:0] m1_sel,
  input  logic [QDW-1:0] m1_dat_w,
  output logic [QDW-1:0] m1_dat_r,
  output logic           m1_ack,
  output logic           m1_err,
  output logic [QAW-1:0] s_adr,
  output logic           s_cs,
  output logic           s_we,
  output logic [QSW-1:0] s_sel,
  output logic [QDW-1:0] s_dat_w,
  input  logic [QDW-1:0] s_dat_r,
  input  logic           s_ack,
  input  logic           s_err
);

  gnt_t gnt;
  gnt_t gnt_nxt;
  logic last;  // 0: master 0 was granted most recently, 1: master 1

  // Next owner. The current owner keeps the slave while its transfer is
  // stalled; once it completes or drops cs, the other master may take over.
  function automatic gnt_t next_gnt(input gnt_t cur, input logic lst,
                                    input logic c0, input logic c1,
                                    input logic ack);
    gnt_t n;
    gnt_t tie;
    n = cur;
`ifdef QMEM_ARB_FIXED_PRIO_EN
    tie = GNT_M0;
`else
    tie = lst ? GNT_M0 : GNT_M1;
`endif
    case (cur)
      GNT_NONE: begin
        if (c0 && c1)  n = tie;
        else if (c0)   n = GNT_M0;
        else if (c1)   n = GNT_M1;
        else           n = GNT_NONE;
      end
      GNT_M0: begin
        if (c0) begin
`ifdef QMEM_ARB_FIXED_PRIO_EN
          n = GNT_M0;
`else
          if (ack) n = c1 ? GNT_M1 : GNT_M0;
`endif
        end else begin
          n = c1 ? GNT_M1 : GNT_NONE;
        end
      end
      GNT_M1: begin
        if (c1) begin
          if (ack) n = c0 ? GNT_M0 : GNT_M1;
        end else begin
          n = c0 ? GNT_M0 : GNT_NONE;
        end
      end
      default: n = GNT_NONE;
    endcase
    return n;
  endfunction

  // Evaluate the grant decision for the coming edge.
  always_comb begin
    gnt_nxt = next_gnt(gnt, last, m0_cs, m1_cs, s_ack);
  end

  // Grant and last-owner registers; reset drops ownership immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= GNT_NONE;
      last <= 1'b1;
    end else begin
      gnt <= gnt_nxt;
      if (gnt_nxt == GNT_M0)      last <= 1'b0;
      else if (gnt_nxt == GNT_M1) last <= 1'b1;
    end
  end

  // Owner mux onto the slave and owner-only ack/err return.
  always_comb begin
    s_adr   = '0;
    s_cs    = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_dat_w = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    case (gnt)
      GNT_M0: begin
        s_adr   = m0_adr;
        s_cs    = m0_cs;
        s_we    = m0_we;
        s_sel   = m0_sel;
        s_dat_w = m0_dat_w;
        m0_ack  = s_ack;
        m0_err  = s_err;
      end
      GNT_M1: begin
        s_adr   = m1_adr;
        s_cs    = m1_cs;
        s_we    = m1_we;
        s_sel   = m1_sel;
        s_dat_w = m1_dat_w;
        m1_ack  = s_ack;
        m1_err  = s_err;
      end
      default: ;
    endcase
  end

  // Read data goes to both masters; each samples it on its own schedule.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

endmodule
